// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - control-hazard unit: branch decode, resolve tracking, freeze/flush, watchdog, stats
module branch_hazard_ctrl #(
   parameter int OP_W       = 6,
   parameter int FN_W       = 6,
   parameter bit PREDICT_NT = 1'b0,
   parameter int MAX_WAIT   = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [OP_W-1:0]  id_opcode,
   input  logic [FN_W-1:0]  id_funct,
   input  logic             ex_resolve,
   input  logic             ex_taken,
   output logic             freeze_if,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             busy,
   output logic             wd_error,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WC_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic             is_jr_q, is_jr_d;
   logic             wd_error_q, wd_error_d;
   logic [CNT_W-1:0] br_q, br_d;
   logic [CNT_W-1:0] st_q, st_d;

   logic dec_cond, dec_jdir, dec_jreg;
   logic accept;

   assign dec_cond = id_valid && ((id_opcode == OP_W'(4)) || (id_opcode == OP_W'(5)));
   assign dec_jdir = id_valid && ((id_opcode == OP_W'(2)) || (id_opcode == OP_W'(3)));
   assign dec_jreg = id_valid && (id_opcode == OP_W'(0)) && (id_funct == FN_W'(8));

   // Next-state and pipeline control; every output is held low while reset is high.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      is_jr_d     = is_jr_q;
      wd_error_d  = wd_error_q;
      freeze_if   = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      accept      = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IDLE: begin
               if (dec_jdir) begin
                  flush_if_id = 1'b1;
               end
               if (dec_cond || dec_jreg) begin
                  freeze_if = dec_jreg || !PREDICT_NT;
                  accept    = 1'b1;
               end
            end
            S_WAIT: begin
               if (ex_resolve) begin
                  state_d = S_IDLE;
                  if (PREDICT_NT) begin
                     if (ex_taken || is_jr_q) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                     end else if (dec_cond) begin
                        accept = 1'b1;
                     end else if (dec_jdir) begin
                        flush_if_id = 1'b1;
                     end else if (dec_jreg) begin
                        // no target to load on a not-taken resolve, so keep jr in ID and let IDLE take it next cycle
                        freeze_if = 1'b1;
                     end
                  end
               end else begin
                  // a second branch-class instruction in ID is held until the outstanding one resolves
                  freeze_if = !PREDICT_NT || is_jr_q || dec_cond || dec_jreg || dec_jdir;
                  if (wcnt_q == WC_W'(MAX_WAIT - 1)) begin
                     wd_error_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     wcnt_d = wcnt_q + WC_W'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (accept) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
            is_jr_d = dec_jreg;
         end
      end
   end

   // Saturating statistics counters.
   always_comb begin
      br_d = br_q;
      st_d = st_q;
      if (accept && !(&br_q)) begin
         br_d = br_q + CNT_W'(1);
      end
      if (freeze_if && !(&st_q)) begin
         st_d = st_q + CNT_W'(1);
      end
   end

   // State, watchdog and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         is_jr_q    <= 1'b0;
         wd_error_q <= 1'b0;
         br_q       <= '0;
         st_q       <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         is_jr_q    <= is_jr_d;
         wd_error_q <= wd_error_d;
         br_q       <= br_d;
         st_q       <= st_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign wd_error    = wd_error_q;
   assign br_count    = br_q;
   assign stall_count = st_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

   localparam logic [5:0] BEQ = 6'd4;
   localparam logic [5:0] BNE = 6'd5;
   localparam logic [5:0] JOP = 6'd2;
   localparam logic [5:0] JAL = 6'd3;
   localparam logic [5:0] JRF = 6'd8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0;
   logic [5:0] id_opcode = 6'd0;
   logic [5:0] id_funct = 6'd0;
   logic       ex_resolve = 1'b0;
   logic       ex_taken = 1'b0;

   logic        fz_o [3];
   logic        fi_o [3];
   logic        fe_o [3];
   logic        busy_o [3];
   logic        wd_o [3];
   logic [15:0] br0, st0, br1, st1;
   logic [3:0]  br2, st2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // u0: freeze mode; u1: predict-not-taken; u2: predict-not-taken, short watchdog, 4-bit counters
   branch_hazard_ctrl #(.OP_W(6), .FN_W(6), .PREDICT_NT(1'b0), .MAX_WAIT(4), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .freeze_if(fz_o[0]), .flush_if_id(fi_o[0]),
      .flush_id_ex(fe_o[0]), .busy(busy_o[0]), .wd_error(wd_o[0]), .br_count(br0), .stall_count(st0));

   branch_hazard_ctrl #(.OP_W(6), .FN_W(6), .PREDICT_NT(1'b1), .MAX_WAIT(4), .CNT_W(16)) u1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .freeze_if(fz_o[1]), .flush_if_id(fi_o[1]),
      .flush_id_ex(fe_o[1]), .busy(busy_o[1]), .wd_error(wd_o[1]), .br_count(br1), .stall_count(st1));

   branch_hazard_ctrl #(.OP_W(6), .FN_W(6), .PREDICT_NT(1'b1), .MAX_WAIT(3), .CNT_W(4)) u2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .freeze_if(fz_o[2]), .flush_if_id(fi_o[2]),
      .flush_id_ex(fe_o[2]), .busy(busy_o[2]), .wd_error(wd_o[2]), .br_count(br2), .stall_count(st2));

   typedef struct {
      bit         vld;
      logic [5:0] op;
      logic [5:0] fn;
      bit         res;
      bit         tkn;
      logic [3:0] e0;
      logic [3:0] e1;
   } vec_t;

   vec_t tbl[$];

   // reference model: pending kind (0 none, 1 conditional, 2 jr), cycles waited, sticky error, counters
   int m_kind [3];
   int m_age  [3];
   bit m_wd   [3];
   int m_br   [3];
   int m_st   [3];
   int p_nt   [3] = '{0, 1, 1};
   int p_mw   [3] = '{4, 4, 3};
   int p_cmax [3] = '{65535, 65535, 15};

   function automatic logic [31:0] get_br(input int k);
      case (k)
         0:       return 32'(br0);
         1:       return 32'(br1);
         default: return 32'(br2);
      endcase
   endfunction

   function automatic logic [31:0] get_st(input int k);
      case (k)
         0:       return 32'(st0);
         1:       return 32'(st1);
         default: return 32'(st2);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit v, input logic [5:0] op, input logic [5:0] fn,
                        input bit rs, input bit tk);
      @(negedge clk);
      reset      = r;
      id_valid   = v;
      id_opcode  = op;
      id_funct   = fn;
      ex_resolve = rs;
      ex_taken   = tk;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic add(input bit v, input logic [5:0] op, input logic [5:0] fn, input bit rs,
                      input bit tk, input logic [3:0] e0, input logic [3:0] e1);
      vec_t t;
      t.vld = v; t.op = op; t.fn = fn; t.res = rs; t.tkn = tk; t.e0 = e0; t.e1 = e1;
      tbl.push_back(t);
   endtask

   task automatic model_step(input int k, output bit fz, output bit fi, output bit fe);
      bit is_cond, is_jdir, is_jreg, taken, started;
      int nk;
      is_cond = id_valid && (id_opcode == BEQ || id_opcode == BNE);
      is_jdir = id_valid && (id_opcode == JOP || id_opcode == JAL);
      is_jreg = id_valid && id_opcode == 6'd0 && id_funct == JRF;
      fz = 0; fi = 0; fe = 0; started = 0;
      if (reset) begin
         m_kind[k] = 0; m_age[k] = 0; m_wd[k] = 0; m_br[k] = 0; m_st[k] = 0;
         return;
      end
      nk = m_kind[k];
      if (m_kind[k] == 0) begin
         fi = is_jdir;
         if (is_cond || is_jreg) begin
            started = 1;
            nk = is_jreg ? 2 : 1;
            fz = is_jreg || p_nt[k] == 0;
         end
      end else if (ex_resolve) begin
         taken = ex_taken || m_kind[k] == 2;
         nk = 0;
         if (p_nt[k] == 1 && taken) begin
            fi = 1; fe = 1;
         end else if (p_nt[k] == 1) begin
            if (is_cond) begin
               started = 1; nk = 1;
            end else if (is_jdir) begin
               fi = 1;
            end else if (is_jreg) begin
               fz = 1;
            end
         end
      end else begin
         fz = p_nt[k] == 0 || m_kind[k] == 2 || is_cond || is_jreg || is_jdir;
         m_age[k]++;
         if (m_age[k] == p_mw[k]) begin
            m_wd[k] = 1; nk = 0;
         end
      end
      if (started) begin
         m_age[k] = 0;
         if (m_br[k] < p_cmax[k]) m_br[k]++;
      end
      if (fz && m_st[k] < p_cmax[k]) m_st[k]++;
      m_kind[k] = nk;
   endtask

   initial begin
      // per-cycle vectors: e = {freeze_if, flush_if_id, flush_id_ex, busy} for u0 / u1
      add(1, BEQ, 0, 0, 0, 4'b1000, 4'b0000);   // beq, resolve taken at cycle 2
      add(0, 0,   0, 0, 0, 4'b1001, 4'b0001);
      add(0, 0,   0, 1, 1, 4'b0001, 4'b0111);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, BNE, 0, 0, 0, 4'b1000, 4'b0000);   // bne, resolve not-taken
      add(0, 0,   0, 0, 0, 4'b1001, 4'b0001);
      add(0, 0,   0, 1, 0, 4'b0001, 4'b0001);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, JOP, 0, 0, 0, 4'b0100, 4'b0100);   // j in IDLE
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, 0, JRF, 0, 0, 4'b1000, 4'b1000);   // jr, resolve not-taken at cycle 3
      add(0, 0,   0, 0, 0, 4'b1001, 4'b1001);
      add(0, 0,   0, 0, 0, 4'b1001, 4'b1001);
      add(0, 0,   0, 1, 0, 4'b0001, 4'b0111);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, BEQ, 0, 0, 0, 4'b1000, 4'b0000);   // back-to-back conditionals
      add(1, BEQ, 0, 0, 0, 4'b1001, 4'b1001);
      add(1, BEQ, 0, 1, 0, 4'b0001, 4'b0001);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0001);
      add(0, 0,   0, 1, 1, 4'b0000, 4'b0111);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, BEQ, 0, 0, 0, 4'b1000, 4'b0000);   // j held behind an outstanding beq
      add(1, JOP, 0, 0, 0, 4'b1001, 4'b1001);
      add(1, JOP, 0, 1, 0, 4'b0001, 4'b0101);
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);
      add(1, JAL, 0, 0, 0, 4'b0100, 4'b0100);   // jal in IDLE
      add(0, 0,   0, 0, 0, 4'b0000, 4'b0000);

      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      idle();
      chk("rst_busy0", 32'(busy_o[0]), 32'd0);
      chk("rst_wd0", 32'(wd_o[0]), 32'd0);
      chk("rst_br0", get_br(0), 32'd0);
      chk("rst_st1", get_st(1), 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(0, tbl[i].vld, tbl[i].op, tbl[i].fn, tbl[i].res, tbl[i].tkn);
         chk($sformatf("vec%0d_u0", i), 32'({fz_o[0], fi_o[0], fe_o[0], busy_o[0]}), 32'(tbl[i].e0));
         chk($sformatf("vec%0d_u1", i), 32'({fz_o[1], fi_o[1], fe_o[1], busy_o[1]}), 32'(tbl[i].e1));
      end

      // counters after one taken beq in freeze mode
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, BEQ, 0, 0, 0);
      idle();
      drive(0, 0, 0, 0, 1, 1);
      idle();
      chk("cnt_st0", get_st(0), 32'd2);
      chk("cnt_br0", get_br(0), 32'd1);
      chk("cnt_busy0", 32'(busy_o[0]), 32'd0);
      chk("cnt_br1", get_br(1), 32'd1);
      chk("cnt_st1", get_st(1), 32'd0);

      // watchdog: beq never resolved
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, BEQ, 0, 0, 0);
      idle(); idle(); idle();
      idle();
      chk("wd_fz_c4", 32'(fz_o[0]), 32'd1);
      chk("wd_early_c4", 32'(wd_o[0]), 32'd0);
      chk("wd_u2_c4", 32'(wd_o[2]), 32'd1);
      idle();
      chk("wd_set0", 32'(wd_o[0]), 32'd1);
      chk("wd_busy0", 32'(busy_o[0]), 32'd0);
      chk("wd_fz_c5", 32'(fz_o[0]), 32'd0);
      chk("wd_st0", get_st(0), 32'd5);
      chk("wd_set1", 32'(wd_o[1]), 32'd1);
      drive(0, 0, 0, 0, 1, 1);
      chk("wd_late_res_fi1", 32'({fi_o[1], fe_o[1]}), 32'd0);
      idle(); idle();
      chk("wd_sticky0", 32'(wd_o[0]), 32'd1);
      drive(1, 0, 0, 0, 0, 0);
      idle();
      chk("wd_clear0", 32'(wd_o[0]), 32'd0);

      // reset while a branch is outstanding
      drive(0, 1, BEQ, 0, 0, 0);
      drive(1, 1, BEQ, 0, 0, 0);
      chk("rstmid_u0", 32'({fz_o[0], fi_o[0], fe_o[0]}), 32'd0);
      chk("rstmid_u1", 32'({fz_o[1], fi_o[1], fe_o[1]}), 32'd0);
      idle();
      chk("rstmid_busy0", 32'(busy_o[0]), 32'd0);
      chk("rstmid_br0", get_br(0), 32'd0);
      chk("rstmid_st0", get_st(0), 32'd0);

      // 20 consecutive conditionals: u1/u2 accept every cycle, u0 every other cycle
      drive(0, 1, BEQ, 0, 0, 0);
      for (int i = 1; i < 20; i++) drive(0, 1, BEQ, 0, 1, 0);
      idle();
      chk("sat_br0", get_br(0), 32'd10);
      chk("sat_st0", get_st(0), 32'd10);
      chk("sat_br1", get_br(1), 32'd20);
      chk("sat_br2", get_br(2), 32'd15);
      chk("sat_st2", get_st(2), 32'd0);

      // randomized run against the model
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         m_kind[k] = 0; m_age[k] = 0; m_wd[k] = 0; m_br[k] = 0; m_st[k] = 0;
      end
      for (int n = 0; n < 3000; n++) begin
         bit r, v, rs, tk;
         logic [5:0] op, fn;
         r = ($urandom_range(0, 49) == 0);
         v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       op = 6'd0;
            1:       op = JOP;
            2:       op = JAL;
            3:       op = BEQ;
            4:       op = BNE;
            default: op = 6'($urandom_range(0, 63));
         endcase
         fn = ($urandom_range(0, 1) == 1) ? JRF : 6'($urandom_range(0, 63));
         rs = ($urandom_range(0, 2) == 0);
         tk = 1'($urandom_range(0, 1));
         drive(r, v, op, fn, rs, tk);
         for (int k = 0; k < 3; k++) begin
            bit efz, efi, efe;
            chk($sformatf("rnd%0d_u%0d_busy", n, k), 32'(busy_o[k]), 32'(m_kind[k] != 0));
            chk($sformatf("rnd%0d_u%0d_wd", n, k), 32'(wd_o[k]), 32'(m_wd[k]));
            chk($sformatf("rnd%0d_u%0d_br", n, k), get_br(k), 32'(m_br[k]));
            chk($sformatf("rnd%0d_u%0d_st", n, k), get_st(k), 32'(m_st[k]));
            model_step(k, efz, efi, efe);
            chk($sformatf("rnd%0d_u%0d_fz", n, k), 32'(fz_o[k]), 32'(efz));
            chk($sformatf("rnd%0d_u%0d_fi", n, k), 32'(fi_o[k]), 32'(efi));
            chk($sformatf("rnd%0d_u%0d_fe", n, k), 32'(fe_o[k]), 32'(efe));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
